// File: rtl/handshake_pkg.sv
// Shared types and elaboration helpers for the handshake constant generators.
package handshake_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Counter width for an index range of 0..n-1, never narrower than one bit.
  function automatic int idx_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/handshake_constant_stride_if.sv
// Control-token input channel and registered data-token output channel.
interface handshake_constant_stride_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  ctrl_valid;
  logic                  ctrl_ready;
  logic [DATA_WIDTH-1:0] outs;
  logic                  outs_valid;
  logic                  outs_ready;
  logic                  outs_last;

  modport master (
    output ctrl_valid, outs_ready,
    input  ctrl_ready, outs, outs_valid, outs_last
  );

  modport slave (
    input  ctrl_valid, outs_ready,
    output ctrl_ready, outs, outs_valid, outs_last
  );

endinterface

// File: rtl/handshake_constant_stride.sv
// Emits BASE, BASE+STRIDE, ... BASE+(COUNT-1)*STRIDE for each accepted control
// token, from a registered output with a zero-bubble restart between bursts.
module handshake_constant_stride
  import handshake_pkg::*;
#(
  parameter int     DATA_WIDTH = 32,
  parameter longint BASE       = 0,
  parameter longint STRIDE     = 1,
  parameter int     COUNT      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  handshake_constant_stride_if.slave bus
);

  localparam int                    IDX_W      = idx_width(COUNT);
  localparam logic [DATA_WIDTH-1:0] BASE_V     = DATA_WIDTH'(BASE);
  localparam logic [DATA_WIDTH-1:0] STRIDE_V   = DATA_WIDTH'(STRIDE);
  localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(COUNT - 1);
  localparam logic                  FIRST_LAST = (COUNT == 1);

  if (COUNT < 1 || COUNT > 65536) begin : g_bad_count
    $fatal(1, "handshake_constant_stride: COUNT must be in 1..65536");
  end

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic [DATA_WIDTH-1:0]   val;
  logic                    last;

  // A new control token is taken in IDLE or while the last token leaves.
  assign bus.ctrl_ready = rst && ((state == IDLE) ||
                                  (last && bus.outs_ready));
  assign bus.outs       = val;
  assign bus.outs_valid = (state == EMIT);
  assign bus.outs_last  = last;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
      val   <= BASE_V;
      last  <= FIRST_LAST;
    end else begin
      case (state)
        IDLE: begin
          if (bus.ctrl_valid) begin
            state <= EMIT;
            idx   <= '0;
            val   <= BASE_V;
            last  <= FIRST_LAST;
          end
        end
        EMIT: begin
          if (bus.outs_ready) begin
            if (!last) begin
              val  <= val + STRIDE_V;
              idx  <= idx + IDX_W'(1);
              last <= (idx + IDX_W'(1) == LAST_IDX);
            end else if (bus.ctrl_valid) begin
              idx  <= '0;
              val  <= BASE_V;
              last <= FIRST_LAST;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_handshake_constant_stride.sv
// Three generator instances checked every cycle against a queue-of-tokens model,
// with directed scenarios pinned by literal expectations, then random traffic.
module tb_handshake_constant_stride;

  localparam int DW = 8;
  localparam longint B0 = 'hF0, S0 = 'h08;
  localparam int     C0 = 4;
  localparam longint B1 = 5,     S1 = -1;
  localparam int     C1 = 3;
  localparam longint B2 = 'h2A,  S2 = 3;
  localparam int     C2 = 1;

  typedef struct {
    logic [DW-1:0] v;
    bit            last;
  } tok_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int base_p[3]   = '{int'(B0), int'(B1), int'(B2)};
  int stride_p[3] = '{int'(S0), int'(S1), int'(S2)};
  int count_p[3]  = '{C0, C1, C2};

  tok_t q[3][$];
  bit   fresh[3];

  logic          cv[3];
  logic          orr[3];
  logic [DW-1:0] d_outs[3];
  logic          d_valid[3];
  logic          d_last[3];
  logic          d_ready[3];

  handshake_constant_stride_if #(.DATA_WIDTH(DW)) bus0 ();
  handshake_constant_stride_if #(.DATA_WIDTH(DW)) bus1 ();
  handshake_constant_stride_if #(.DATA_WIDTH(DW)) bus2 ();

  handshake_constant_stride #(.DATA_WIDTH(DW), .BASE(B0), .STRIDE(S0), .COUNT(C0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  handshake_constant_stride #(.DATA_WIDTH(DW), .BASE(B1), .STRIDE(S1), .COUNT(C1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));
  handshake_constant_stride #(.DATA_WIDTH(DW), .BASE(B2), .STRIDE(S2), .COUNT(C2))
    dut2 (.clk(clk), .rst(rst), .bus(bus2));

  assign bus0.ctrl_valid = cv[0];  assign bus0.outs_ready = orr[0];
  assign bus1.ctrl_valid = cv[1];  assign bus1.outs_ready = orr[1];
  assign bus2.ctrl_valid = cv[2];  assign bus2.outs_ready = orr[2];
  assign d_outs[0] = bus0.outs;  assign d_valid[0] = bus0.outs_valid;
  assign d_outs[1] = bus1.outs;  assign d_valid[1] = bus1.outs_valid;
  assign d_outs[2] = bus2.outs;  assign d_valid[2] = bus2.outs_valid;
  assign d_last[0] = bus0.outs_last;  assign d_ready[0] = bus0.ctrl_ready;
  assign d_last[1] = bus1.outs_last;  assign d_ready[1] = bus1.ctrl_ready;
  assign d_last[2] = bus2.outs_last;  assign d_ready[2] = bus2.ctrl_ready;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Control is taken when nothing is pending, or when only the last token of
  // the current burst remains and it is leaving now.
  function automatic bit exp_ctrl_ready(input int k);
    return rst && (q[k].size() == 0 || (q[k].size() == 1 && orr[k]));
  endfunction

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      bit exp_valid;
      exp_valid = (q[k].size() != 0);
      check($sformatf("outs_valid[%0d]", k), d_valid[k], exp_valid);
      check($sformatf("ctrl_ready[%0d]", k), d_ready[k], exp_ctrl_ready(k));
      if (exp_valid) begin
        check($sformatf("outs[%0d]", k), d_outs[k], q[k][0].v);
        check($sformatf("outs_last[%0d]", k), d_last[k], q[k][0].last);
      end else if (fresh[k]) begin
        check($sformatf("idle_outs[%0d]", k), d_outs[k], base_p[k][DW-1:0]);
        check($sformatf("idle_last[%0d]", k), d_last[k], (count_p[k] == 1));
      end
    end
  endtask

  // Model of the coming rising edge, using the inputs currently driven.
  task automatic update_model();
    for (int k = 0; k < 3; k++) begin
      bit cr;
      cr = exp_ctrl_ready(k);
      if (rst && q[k].size() != 0 && orr[k]) void'(q[k].pop_front());
      if (cv[k] && cr) begin
        for (int i = 0; i < count_p[k]; i++) begin
          tok_t t;
          t.v    = DW'(base_p[k] + i * stride_p[k]);
          t.last = (i == count_p[k] - 1);
          q[k].push_back(t);
        end
        fresh[k] = 1'b0;
      end
    end
  endtask

  task automatic step();
    update_model();
    @(negedge clk);
    check_all();
  endtask

  task automatic assert_reset();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      q[k].delete();
      fresh[k] = 1'b1;
    end
  endtask

  logic [DW-1:0] wrap_outs[4] = '{8'hF0, 8'hF8, 8'h00, 8'h08};
  bit            wrap_last[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [DW-1:0] bp_outs[6]   = '{8'h05, 8'h04, 8'h04, 8'h04, 8'h04, 8'h03};

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cv[k]  = 1'b0;
      orr[k] = 1'b1;
    end
    #1 assert_reset();
    step();
    step();
    rst = 1'b1;

    // Idle control: nothing requested, outputs sit at reset values.
    repeat (10) step();
    check("idle_base_lit", d_outs[0], 8'hF0);
    check("idle_valid_lit", d_valid[0], 1'b0);

    // Wrap-around single burst.
    cv[0] = 1'b1;
    check("wrap_ready_idle", d_ready[0], 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      cv[0] = 1'b0;
      check("wrap_outs_lit", d_outs[0], wrap_outs[i]);
      check("wrap_last_lit", d_last[0], wrap_last[i]);
    end
    step();
    check("wrap_valid_fall", d_valid[0], 1'b0);

    // Back-to-back bursts with ctrl_valid held for two tokens.
    cv[0] = 1'b1;
    check("b2b_ready_c0", d_ready[0], 1'b1);
    for (int i = 0; i < 8; i++) begin
      step();
      check("b2b_valid_lit", d_valid[0], 1'b1);
      if (i == 1) check("b2b_ready_mid", d_ready[0], 1'b0);
      if (i == 3) check("b2b_ready_last", d_ready[0], 1'b1);
      if (i == 4) cv[0] = 1'b0;
    end
    step();
    check("b2b_valid_fall", d_valid[0], 1'b0);

    // Backpressure on the second token of a descending burst.
    cv[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      cv[1] = 1'b0;
      check("bp_outs_lit", d_outs[1], bp_outs[i]);
      check("bp_valid_lit", d_valid[1], 1'b1);
      if (i < 5) check("bp_ready_lit", d_ready[1], 1'b0);
      if (i == 1) orr[1] = 1'b0;
      if (i == 4) orr[1] = 1'b1;
    end
    check("bp_ready_last", d_ready[1], 1'b1);
    step();
    check("bp_valid_fall", d_valid[1], 1'b0);

    // COUNT=1: two control pulses on consecutive cycles, both consumed.
    cv[2] = 1'b1;
    check("c1_ready_c0", d_ready[2], 1'b1);
    step();
    check("c1_outs_c1", d_outs[2], 8'h2A);
    check("c1_last_c1", d_last[2], 1'b1);
    check("c1_ready_c1", d_ready[2], 1'b1);
    step();
    cv[2] = 1'b0;
    check("c1_outs_c2", d_outs[2], 8'h2A);
    check("c1_valid_c2", d_valid[2], 1'b1);
    step();
    check("c1_valid_c3", d_valid[2], 1'b0);

    // Reset during the second token of a burst.
    cv[0] = 1'b1;
    step();
    cv[0] = 1'b0;
    step();
    check("rst_pre_outs", d_outs[0], 8'hF8);
    #1 assert_reset();
    #1;
    check("rst_async_valid", d_valid[0], 1'b0);
    check("rst_async_ready", d_ready[0], 1'b0);
    step();
    step();
    rst = 1'b1;
    cv[0] = 1'b1;
    step();
    cv[0] = 1'b0;
    check("rst_restart_lit", d_outs[0], 8'hF0);
    repeat (4) step();

    // Random traffic with occasional asynchronous resets.
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 3; k++) begin
        cv[k]  = ($urandom_range(0, 3) != 0);
        orr[k] = ($urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 399) == 0) begin
        #($urandom_range(1, 4)) assert_reset();
        repeat ($urandom_range(1, 2)) step();
        rst = 1'b1;
      end else begin
        step();
      end
    end

    for (int k = 0; k < 3; k++) begin
      cv[k]  = 1'b0;
      orr[k] = 1'b1;
    end
    repeat (6) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/handshake_constant_stride.md
# handshake_constant_stride

Elastic dataflow constant generator that emits an arithmetic sequence in response to control tokens. Each token accepted on the control channel produces a burst of COUNT data tokens, BASE, BASE+STRIDE, … BASE+(COUNT-1)·STRIDE, on the output channel from a registered output. It replaces the purely combinational constant unit wherever a loop needs a constant index sequence, or where the constant path must be cut by a register. COUNT=1 degenerates to a registered single constant.

## Interface
- DATA_WIDTH, 32: width of `outs`.
- BASE, 0: first value of every burst, truncated to DATA_WIDTH.
- STRIDE, 1: increment between consecutive tokens, truncated to DATA_WIDTH, two's-complement, so negative strides are legal.
- COUNT, 4: tokens per control token. Legal range is 1..2^16.
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous assert, active-low. Deassertion is synchronised externally.
- ctrl_valid  in  1  control token present. The token carries no data.
- ctrl_ready  out  1  control token consumed this cycle.
- outs  out  DATA_WIDTH  current sequence value, registered.
- outs_valid  out  1  `outs` holds a valid token, registered.
- outs_ready  in  1  downstream accepts the token.
- outs_last  out  1  current token is the last of its burst, registered.

## Operation
- States:
  - IDLE: no token is pending.
  - EMIT: a token is held on `outs`.
- Internal registers: `state`, `idx` (width max(1, clog2(COUNT))), `val` (drives `outs`).
- IDLE:
  - `ctrl_ready=1`, `outs_valid=0`.
  - On `ctrl_valid`: go to EMIT with `val=BASE`, `idx=0`, `outs_last=(COUNT==1)`.
- EMIT with `outs_valid=1` and `outs_ready=1`, when not last (`idx<COUNT-1`):
  - `val <= val+STRIDE`, modulo 2^DATA_WIDTH, so wrap-around is silent.
  - `idx <= idx+1`.
  - `outs_last <= (idx+1==COUNT-1)`.
- EMIT with `outs_ready=1`, when last:
  - `ctrl_ready=1` combinationally.
  - If `ctrl_valid=1`: restart the burst at once (`val=BASE`, `idx=0`), stay in EMIT with no bubble.
  - Otherwise go to IDLE.
- `ctrl_ready` is 0 in EMIT unless the last token is handshaking this cycle. Control tokens are never buffered.
- `outs_ready=0`: `outs`, `outs_valid` and `outs_last` hold stable, which is the standard valid/ready persistence rule.
- The value is computed incrementally. No multiplier is allowed.
- Reset asserted at any time, including mid-burst:
  - The burst is aborted. State goes to IDLE, `idx=0`, `val=BASE`.
  - `outs_valid=0`, `outs_last=(COUNT==1)`.
  - `ctrl_ready` is forced 0 while rst is low.
  - No partial burst resumes after reset.

## Timing
- Reset values: `outs=BASE`, `outs_valid=0`, `outs_last=(COUNT==1)`, `ctrl_ready=0` (held low while rst is low).
- Latency: control handshake at edge t gives `outs_valid=1` with `outs=BASE` after edge t.
- Throughput: one token per cycle while `outs_ready=1`. A burst takes exactly COUNT cycles.
- Back-to-back bursts with a continuous `ctrl_valid` have zero idle cycles.
- Combinational paths:
  - `ctrl_ready` depends on `outs_ready` (one gate path).
  - `outs` and `outs_valid` have no combinational input dependency.
- `ctrl_valid` arriving in IDLE while `outs_ready=0`: the token is still accepted, and the first output token waits.

## Structure
- Shared package `handshake_pkg` holds:
  - the state enum {IDLE, EMIT};
  - the `idx` width helper, max(1, clog2(N)).
- Single flat module. No sub-module is warranted; the counter and the value register are a few lines each.
- Elaboration-time check: COUNT < 1 or COUNT > 65536 is a fatal error.

## Test plan
- Wrap-around: DATA_WIDTH=8, BASE=0xF0, STRIDE=0x08, COUNT=4, one `ctrl_valid` pulse, `outs_ready=1`.
  - Expect `outs` = 0xF0, 0xF8, 0x00, 0x08 on consecutive cycles.
  - Expect `outs_last` on 0x08 only. `outs_valid` falls the next cycle.
- Back-to-back bursts: same parameters, `ctrl_valid` held high for 2 tokens.
  - Expect 8 consecutive valid cycles with no bubble.
  - Expect `ctrl_ready` high at cycle 0 (IDLE) and at cycle 3 (last handshake).
- Backpressure: BASE=5, STRIDE=-1 (0xFF), COUNT=3, `outs_ready` low for 3 cycles on the second token.
  - Expect `outs`=4 held stable with `outs_valid=1`.
  - Full sequence is 5, 4, 3. `ctrl_ready` stays 0 until 3 is accepted.
- COUNT=1, BASE=0x2A: `ctrl_valid` pulses on cycles 0 and 1.
  - Expect 0x2A valid on cycles 1 and 2, `outs_last=1` always.
  - Both control tokens are consumed.
- Reset mid-burst: COUNT=4, rst driven low during the second token.
  - Expect `outs_valid=0` and `ctrl_ready=0` immediately (asynchronously).
  - After release, a new token restarts at BASE.
- Idle control: `ctrl_valid=0` for 10 cycles → `outs_valid` stays 0 and `outs` stays equal to BASE.
